// File: rtl/sqrt_iter_engine.sv
// Handshaked iterative integer square root: root = floor(sqrt(din)), rem = din - root^2.
// Optional macro SQRT_ROUND_EN adds a registered round-to-nearest output root_rnd.
module sqrt_iter_engine #(
  parameter int DIN_W = 16,
  parameter int STEPS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DIN_W-1:0]   din,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DIN_W/2-1:0] root,
  output logic [DIN_W/2:0]   rem,
  output logic               busy
`ifdef SQRT_ROUND_EN
  ,
  output logic [DIN_W/2:0]   root_rnd
`endif
);

  localparam int ROOT_W = DIN_W / 2;
  localparam int NCYC   = ROOT_W / STEPS;
  localparam int RW1    = ROOT_W + 1;
  localparam int TW     = ROOT_W + 4;
  localparam int CNT_W  = $clog2(NCYC + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [DIN_W-1:0]   rad;
  logic [ROOT_W-1:0]  wroot;
  logic [RW1-1:0]     wrem;
  logic [CNT_W-1:0]   cnt;

  logic [DIN_W-1:0]   nrad;
  logic [ROOT_W-1:0]  nroot;
  logic [RW1-1:0]     nrem;
  logic [TW-1:0]      trial;

  // STEPS digit iterations per clock; the trial is kept wide enough that its MSB is a clean sign.
  always_comb begin
    nrad  = rad;
    nroot = wroot;
    nrem  = wrem;
    trial = '0;
    for (int i = 0; i < STEPS; i++) begin
      trial = {1'b0, nrem, nrad[DIN_W-1 -: 2]} - {2'b00, nroot, 2'b01};
      if (!trial[TW-1]) begin
        nrem  = RW1'(trial);
        nroot = ROOT_W'({nroot, 1'b1});
      end else begin
        nrem  = RW1'({nrem, nrad[DIN_W-1 -: 2]});
        nroot = ROOT_W'({nroot, 1'b0});
      end
      nrad = nrad << 2;
    end
  end

`ifdef SQRT_ROUND_EN
  logic [RW1-1:0] nrnd;
  always_comb begin
    nrnd = {1'b0, nroot} + RW1'(nrem > {1'b0, nroot});
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      root      <= '0;
      rem       <= '0;
      rad       <= '0;
      wroot     <= '0;
      wrem      <= '0;
      cnt       <= '0;
`ifdef SQRT_ROUND_EN
      root_rnd  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            rad      <= din;
            wroot    <= '0;
            wrem     <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          rad   <= nrad;
          wroot <= nroot;
          wrem  <= nrem;
          cnt   <= cnt + CNT_W'(1);
          // Results land in the output registers only at completion so root/rem never show partials.
          if (cnt == CNT_W'(NCYC - 1)) begin
            root      <= nroot;
            rem       <= nrem;
`ifdef SQRT_ROUND_EN
            root_rnd  <= nrnd;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_iter_engine.sv
// Self-checking bench for sqrt_iter_engine: default 16-bit instance and a 32-bit, two-steps-per-cycle instance.
module tb_sqrt_iter_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1, a_busy;
  logic [15:0] a_din = '0;
  logic [7:0]  a_root;
  logic [8:0]  a_rem;

  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_busy;
  logic [31:0] b_din = '0;
  logic [15:0] b_root;
  logic [16:0] b_rem;

`ifdef SQRT_ROUND_EN
  logic [8:0]  a_rnd;
  logic [16:0] b_rnd;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sqrt_iter_engine #(.DIN_W(16), .STEPS(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .din(a_din),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .root(a_root), .rem(a_rem), .busy(a_busy)
`ifdef SQRT_ROUND_EN
    , .root_rnd(a_rnd)
`endif
  );

  sqrt_iter_engine #(.DIN_W(32), .STEPS(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .din(b_din),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .root(b_root), .rem(b_rem), .busy(b_busy)
`ifdef SQRT_ROUND_EN
    , .root_rnd(b_rnd)
`endif
  );

  typedef struct {
    logic [15:0] din;
    logic [7:0]  root;
    logic [8:0]  rem;
    logic [8:0]  rnd;
  } vec_t;

  vec_t vecs[7];

  // Largest r with r*r <= x, by binary search over plain integers.
  function automatic longint isqrt(input longint x);
    longint lo = 0, hi = 65536, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= x) lo = mid; else hi = mid;
    end
    return lo;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Hands one radicand to the 16-bit engine and waits for its result, checking the latency.
  task automatic applyStimulus(input logic [15:0] d);
    int waited = 0;
    int lat = 0;
    while (!a_in_ready && waited < 50) begin @(posedge clk); #1; waited++; end
    checkOutput("a in_ready before accept", a_in_ready, 1);
    a_din = d;
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    while (!a_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    checkOutput("a latency", lat, 8);
  endtask

  task automatic runWide(input logic [31:0] d);
    int waited = 0;
    int lat = 0;
    longint r;
    while (!b_in_ready && waited < 50) begin @(posedge clk); #1; waited++; end
    checkOutput("b in_ready before accept", b_in_ready, 1);
    b_din = d;
    b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    while (!b_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    checkOutput("b latency", lat, 8);
    r = isqrt(longint'(d));
    checkOutput("b root", b_root, r);
    checkOutput("b rem", b_rem, longint'(d) - r * r);
`ifdef SQRT_ROUND_EN
    checkOutput("b root_rnd", b_rnd, r + ((longint'(d) - r * r) > r ? 1 : 0));
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    int seen;
    longint r;
    logic [15:0] rd;

    vecs[0] = '{16'd3,     8'd1,   9'd2,   9'd2};
    vecs[1] = '{16'd7,     8'd2,   9'd3,   9'd3};
    vecs[2] = '{16'd11,    8'd3,   9'd2,   9'd3};
    vecs[3] = '{16'd0,     8'd0,   9'd0,   9'd0};
    vecs[4] = '{16'd65025, 8'd255, 9'd0,   9'd255};
    vecs[5] = '{16'd65535, 8'd255, 9'd510, 9'd256};
    vecs[6] = '{16'd50000, 8'd223, 9'd271, 9'd224};

    // Reset held for three cycles, outputs idle throughout
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset in_ready", a_in_ready, 0);
    checkOutput("reset out_valid", a_out_valid, 0);
    checkOutput("reset busy", a_busy, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle in_ready", a_in_ready, 1);
    checkOutput("idle root", a_root, 0);
    checkOutput("idle rem", a_rem, 0);
    checkOutput("idle out_valid", a_out_valid, 0);

    // Table vectors with out_ready tied high
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].din);
      checkOutput("vec root", a_root, vecs[i].root);
      checkOutput("vec rem", a_rem, vecs[i].rem);
      checkOutput("vec busy", a_busy, 1);
`ifdef SQRT_ROUND_EN
      checkOutput("vec root_rnd", a_rnd, vecs[i].rnd);
`endif
      @(posedge clk); #1;
      checkOutput("vec retired", a_out_valid, 0);
    end

    // Back-pressure: result held, second request ignored, retire with in_valid still high
    a_out_ready = 1'b0;
    applyStimulus(16'd11);
    a_din = 16'd7;
    a_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("stall out_valid", a_out_valid, 1);
      checkOutput("stall root", a_root, 3);
      checkOutput("stall rem", a_rem, 2);
      checkOutput("stall in_ready", a_in_ready, 0);
    end
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    checkOutput("stall retire out_valid", a_out_valid, 0);
    checkOutput("stall retire busy", a_busy, 0);
    checkOutput("stall retire in_ready", a_in_ready, 1);
    checkOutput("stall root kept", a_root, 3);

    // Mid-operation reset abandons the job
    a_din = 16'd50000;
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("midreset out_valid", a_out_valid, 0);
    checkOutput("midreset root", a_root, 0);
    checkOutput("midreset rem", a_rem, 0);
    checkOutput("midreset busy", a_busy, 0);
    checkOutput("midreset in_ready", a_in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (a_out_valid) seen++;
    end
    checkOutput("no result after reset", seen, 0);
    applyStimulus(16'd50000);
    checkOutput("post-reset root", a_root, 223);
    checkOutput("post-reset rem", a_rem, 271);
    @(posedge clk); #1;

    // Random sweep of the 16-bit engine
    for (int i = 0; i < 150; i++) begin
      rd = 16'($urandom_range(0, 65535));
      applyStimulus(rd);
      r = isqrt(longint'(rd));
      checkOutput("rand root", a_root, r);
      checkOutput("rand rem", a_rem, longint'(rd) - r * r);
`ifdef SQRT_ROUND_EN
      checkOutput("rand root_rnd", a_rnd, r + ((longint'(rd) - r * r) > r ? 1 : 0));
`endif
      @(posedge clk); #1;
    end

    // Wide engine: extremes then a random sweep
    runWide(32'hFFFF_FFFF);
    checkOutput("wide max root", b_root, 65535);
    checkOutput("wide max rem", b_rem, 131070);
    runWide(32'd0);
    runWide(32'd4294836225);
    for (int i = 0; i < 1000; i++) begin
      runWide($urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
